irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Machine-mode interrupt controller inside the core. It sits directly downstream of the timer/software-interrupt unit and consumes its m_sip/m_tip lines, plus one asynchronous external interrupt pin.
- Combines these sources with mstatus.MIE and the mie enables, and resolves priority.
- Runs a request/acknowledge handshake with the pipeline so an interrupt is taken only at an instruction boundary.
- Emits a one-cycle trap pulse carrying target PC, mcause and mepc to the CSR file and fetch redirect.

Parameters:
- XLEN, 32, data/address width.
- SYNC_STAGES, 2, flop stages on ext_irq (minimum 2).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- ext_irq  in  1  external interrupt pin, asynchronous to clk, level.
- m_sip  in  1  machine software interrupt pending, level, clk domain.
- m_tip  in  1  machine timer interrupt pending, level, clk domain.
- mstatus_mie  in  1  global machine interrupt enable.
- mie_meie  in  1  external interrupt enable (mie[11]).
- mie_mtie  in  1  timer interrupt enable (mie[7]).
- mie_msie  in  1  software interrupt enable (mie[3]).
- mtvec  in  XLEN  trap vector CSR.
- epc  in  XLEN  PC of the oldest not-yet-committed instruction.
- irq_req  out  1  request to pipeline to drain and stop at a boundary.
- irq_ack  in  1  pipeline is at a boundary; epc is valid this cycle.
- trap_valid  out  1  one-cycle trap-take pulse.
- trap_pc  out  XLEN  redirect target.
- trap_mcause  out  XLEN  value for mcause.
- trap_mepc  out  XLEN  value for mepc.
- mip  out  XLEN  read view for the mip CSR: bit11 = MEIP, bit7 = MTIP, bit3 = MSIP, others 0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; sync chain 0.
- ext_irq passes through SYNC_STAGES flops to give meip_s. m_sip and m_tip are used directly.
- mip is combinational from meip_s, m_tip and m_sip.
- pend = {meip_s & mie_meie, m_sip & mie_msie, m_tip & mie_mtie}.
- take = mstatus_mie & |pend.
- Priority is fixed: external (code 11) > software (code 3) > timer (code 7).
- cause_nxt is the code of the highest-priority set bit of pend.
- FSM states: IDLE, REQ, TRAP.
  - IDLE: if take, go to REQ and latch cause_nxt into cause_q. Otherwise stay.
  - REQ: irq_req = 1.
    - If irq_ack: go to TRAP, latch epc into mepc_q.
    - Else if !take: go back to IDLE (request withdrawn; irq_req drops next cycle).
    - Else: stay, and refresh cause_q with cause_nxt so a higher-priority arrival upgrades the cause.
    - ack and !take in the same cycle: ack wins; commit with cause_q as latched at the previous edge.
  - TRAP: trap_valid = 1 for exactly one cycle, then go to IDLE.
    - trap_mcause = {1'b1, (XLEN-5)'b0, cause_q[3:0]}.
    - trap_mepc = mepc_q.
    - trap_pc = {mtvec[XLEN-1:2], 2'b00} (direct mode).
- The CSR file clears mstatus.MIE on trap_valid, so IDLE cannot re-request the cycle after TRAP.
- Latency: m_tip rising with enables set gives irq_req at cycle +1. irq_ack at cycle N gives trap_valid at N+1.
- irq_ack outside REQ is ignored.
- Outputs trap_valid and irq_req come from the state register and are registered (no combinational path from inputs).
- Reset mid-handshake returns the FSM to IDLE with no trap pulse.

Optional Feature:
- Macro IRQ_VECTORED_EN.
- When defined: if mtvec[1:0] == 2'b01, trap_pc = {mtvec[XLEN-1:2], 2'b00} + (cause_q << 2). Any other mode uses direct.
- When undefined: mtvec[1:0] is ignored and trap_pc is always direct.

Decomposition:
- Shared defines header holds:
  - Cause codes IRQ_CODE_MEI = 11, IRQ_CODE_MSI = 3, IRQ_CODE_MTI = 7.
  - mip/mie bit positions.
  - FSM state encodings.
  - MTVEC_MODE_VECTORED = 2'b01.
- One sub-module: irq_sync (parameterised SYNC_STAGES flop chain with asynchronous reset), reused for any future asynchronous pins.

Test Plan:
1. Reset asserted mid-REQ → irq_req = 0 and trap_valid = 0 immediately; FSM in IDLE; mip = 0.
2. mstatus_mie = 1, mie_mtie = 1, m_tip 0→1 → irq_req at +1. Then irq_ack with epc = 0x80000040 → trap_valid one cycle, trap_mcause = 0x80000007, trap_mepc = 0x80000040, trap_pc = mtvec & ~3.
3. m_tip, m_sip and ext_irq all asserted, all enables on → after sync delay and ack, trap_mcause = 0x8000000B. Then with ext_irq low and m_sip held → next trap has cause 0x80000003.
4. In REQ, mstatus_mie drops with no ack → irq_req falls next cycle, no trap_valid. Repeat with irq_ack in the same cycle → trap_valid is issued.
5. Timer pending in REQ, ext_irq arrives before ack → trap_mcause upgrades to 0x8000000B.
6. With IRQ_VECTORED_EN defined, mtvec = 0x00001001, timer trap → trap_pc = 0x0000101C. Without the macro → trap_pc = 0x00001000.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions: cause codes, mip/mie bit positions,
// FSM encodings and the mtvec mode value.
package irq_ctrl_pkg;

    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;

    localparam int MIP_MEIP_BIT = 11;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MSIP_BIT = 3;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_TRAP = 2'd2
    } irq_state_e;

    // pend = {ext, sw, timer}; fixed priority ext > sw > timer
    function automatic logic [3:0] irq_cause(input logic [2:0] pend);
        if (pend[2])
            return IRQ_CODE_MEI;
        else if (pend[1])
            return IRQ_CODE_MSI;
        else if (pend[0])
            return IRQ_CODE_MTI;
        return 4'd0;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: STAGES-deep synchroniser for an asynchronous level input.
// STAGES must be at least 2.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller with req/ack handshake.
// Define IRQ_VECTORED_EN to enable vectored mtvec mode.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq,
    input  logic            m_sip,
    input  logic            m_tip,
    input  logic            mstatus_mie,
    input  logic            mie_meie,
    input  logic            mie_mtie,
    input  logic            mie_msie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] epc,
    output logic            irq_req,
    input  logic            irq_ack,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] trap_mcause,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] mip
);

    irq_state_e      state;
    logic [3:0]      cause_q;
    logic [XLEN-1:0] mepc_q;
    logic            meip_s;
    logic [2:0]      pend;
    logic [3:0]      cause_nxt;
    logic            take;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] vec_off;

    irq_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk(clk),
        .rst(rst),
        .d  (ext_irq),
        .q  (meip_s)
    );

    always_comb begin
        mip               = '0;
        mip[MIP_MEIP_BIT] = meip_s;
        mip[MIP_MTIP_BIT] = m_tip;
        mip[MIP_MSIP_BIT] = m_sip;
    end

    assign pend = {meip_s & mie_meie,
                   m_sip  & mie_msie,
                   m_tip  & mie_mtie};

    assign take      = mstatus_mie & (|pend);
    assign cause_nxt = irq_cause(pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cause_q <= '0;
            mepc_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (take) begin
                        state   <= ST_REQ;
                        cause_q <= cause_nxt;
                    end
                end
                ST_REQ: begin
                    // ack wins over withdrawal; cause stays as latched
                    if (irq_ack) begin
                        state  <= ST_TRAP;
                        mepc_q <= epc;
                    end else if (!take) begin
                        state <= ST_IDLE;
                    end else begin
                        cause_q <= cause_nxt;
                    end
                end
                ST_TRAP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign irq_req    = (state == ST_REQ);
    assign trap_valid = (state == ST_TRAP);

    assign tvec_base = mtvec & ~XLEN'(3);

`ifdef IRQ_VECTORED_EN
    assign vec_off = (mtvec[1:0] == MTVEC_MODE_VECTORED)
                   ? {{(XLEN-6){1'b0}}, cause_q, 2'b00}
                   : '0;
`else
    assign vec_off = '0;
`endif

    assign trap_pc     = trap_valid ? tvec_base + vec_off : '0;
    assign trap_mcause = trap_valid ? {1'b1, {(XLEN-5){1'b0}}, cause_q} : '0;
    assign trap_mepc   = trap_valid ? mepc_q : '0;

endmodule
